// File: rtl/mul_arbiter.sv
// Two-requester round-robin arbiter in front of an iterative shift-add multiplier.
// One operation at a time: IDLE accepts, RUN spends WIDTH cycles, DONE publishes.
module mul_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 done0,
  output logic                 done1,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 owner
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_next;
  logic                 grant;
  logic                 grant_id;
  logic                 prio;      // requester favoured when both ask
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mplier;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_id   = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant      = 1'b1;
          grant_id   = (req0 && req1) ? prio : req1;
          state_next = RUN;
        end
      end
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign busy     = (state == RUN) || (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      result <= '0;
      owner  <= 1'b0;
      prio   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      gnt0  <= grant && !grant_id;
      gnt1  <= grant &&  grant_id;
      // The done pulse trails the DONE state by one edge, mirroring how gnt
      // trails acceptance; this leaves one IDLE cycle between operations.
      done0 <= (state == DONE) && !owner;
      done1 <= (state == DONE) &&  owner;
      if (grant) begin
        owner  <= grant_id;
        prio   <= !grant_id;
        cnt    <= '0;
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, grant_id ? a1 : a0};
        mplier <= grant_id ? b1 : b0;
      end else if (state == RUN) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (cnt == LAST) result <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Randomised and directed bench for mul_arbiter; expectations come from a
// transaction-level model (products, round-robin winner, fixed latencies).
module tb_mul_arbiter;

  localparam int W      = 8;
  localparam int BUDGET = 4 * W + 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic           gnt0, gnt1, done0, done1, busy, owner;
  logic [2*W-1:0] result;

  int errors = 0;
  int checks = 0;

  mul_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observers only: return which requester pulsed (2 = both) and after how
  // many falling edges; -1/-1 on timeout.
  task automatic wait_gnt(output int which, output int cyc);
    which = -1;
    cyc   = -1;
    for (int i = 1; i <= BUDGET; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        which = (gnt0 && gnt1) ? 2 : (gnt1 ? 1 : 0);
        cyc   = i;
        return;
      end
    end
  endtask

  task automatic wait_done(output int which, output int cyc);
    which = -1;
    cyc   = -1;
    for (int i = 1; i <= BUDGET; i++) begin
      @(negedge clk);
      if (done0 || done1) begin
        which = (done0 && done1) ? 2 : (done1 ? 1 : 0);
        cyc   = i;
        return;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, owner} !== 6'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b%b done=%b%b busy=%b owner=%b result=%h, want all zero",
               gnt0, gnt1, done0, done1, busy, owner, result);
    end
    apply_reset();
  endtask

  task automatic test_single();
    int w, c;
    apply_reset();
    a0 = 8'd20; b0 = 8'd23; req0 = 1'b1;
    wait_gnt(w, c);
    req0 = 1'b0;
    checks++;
    if (w !== 0 || c !== 1) begin
      errors++;
      $display("FAIL single_gnt: which=%0d cyc=%0d, want 0/1", w, c);
    end
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_gnt_pulse: gnt0=%b busy=%b, want 0/1", gnt0, busy);
    end
    wait_done(w, c);
    checks++;
    if (w !== 0 || c !== W || result !== 16'h01CC || owner !== 1'b0) begin
      errors++;
      $display("FAIL single_done: which=%0d cyc=%0d result=%h owner=%b, want 0/%0d/01cc/0",
               w, c, result, owner, W);
    end
  endtask

  task automatic test_simultaneous();
    int w, c;
    apply_reset();
    a0 = 8'd3; b0 = 8'd4; a1 = 8'd5; b1 = 8'd6;
    req0 = 1'b1; req1 = 1'b1;
    wait_gnt(w, c);
    if (w == 0) req0 = 1'b0;
    checks++;
    if (w !== 0 || c !== 1) begin
      errors++;
      $display("FAIL simul_gnt_first: which=%0d cyc=%0d, want 0/1", w, c);
    end
    wait_done(w, c);
    checks++;
    if (w !== 0 || c !== W + 1 || result !== 16'd12) begin
      errors++;
      $display("FAIL simul_done_first: which=%0d cyc=%0d result=%0d, want 0/%0d/12", w, c, result, W + 1);
    end
    req0 = 1'b0;
    wait_gnt(w, c);
    req1 = 1'b0;
    checks++;
    if (w !== 1 || c !== 1) begin
      errors++;
      $display("FAIL simul_gnt_second: which=%0d cyc=%0d, want 1/1", w, c);
    end
    wait_done(w, c);
    checks++;
    if (w !== 1 || c !== W + 1 || result !== 16'd30 || owner !== 1'b1) begin
      errors++;
      $display("FAIL simul_done_second: which=%0d cyc=%0d result=%0d owner=%b, want 1/%0d/30/1",
               w, c, result, owner, W + 1);
    end
  endtask

  task automatic test_back_to_back();
    int w, c;
    int exp_p;
    apply_reset();
    a0 = 8'd7; b0 = 8'd9; a1 = 8'd11; b1 = 8'd13;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_p = (k % 2 == 0) ? 63 : 143;
      wait_gnt(w, c);
      checks++;
      if (w !== k % 2 || c !== 1) begin
        errors++;
        $display("FAIL b2b_gnt%0d: which=%0d cyc=%0d, want %0d/1", k, w, c, k % 2);
      end
      wait_done(w, c);
      if (k == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      checks++;
      if (w !== k % 2 || c !== W + 1 || result !== 16'(exp_p) || busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_done%0d: which=%0d cyc=%0d result=%0d busy=%b, want %0d/%0d/%0d/0",
                 k, w, c, result, busy, k % 2, W + 1, exp_p);
      end
    end
  endtask

  task automatic test_extremes();
    int w, c;
    apply_reset();
    a1 = 8'hFF; b1 = 8'hFF; req1 = 1'b1;
    wait_gnt(w, c);
    req1 = 1'b0;
    wait_done(w, c);
    checks++;
    if (w !== 1 || c !== W + 1 || result !== 16'hFE01) begin
      errors++;
      $display("FAIL max_operands: which=%0d cyc=%0d result=%h, want 1/%0d/fe01", w, c, result, W + 1);
    end
    a0 = 8'h00; b0 = 8'h37; req0 = 1'b1;
    wait_gnt(w, c);
    req0 = 1'b0;
    wait_done(w, c);
    checks++;
    if (w !== 0 || c !== W + 1 || result !== 16'h0000) begin
      errors++;
      $display("FAIL zero_operand: which=%0d cyc=%0d result=%h, want 0/%0d/0000", w, c, result, W + 1);
    end
  endtask

  task automatic test_reset_abort();
    int w, c;
    bit seen_done;
    apply_reset();
    a0 = 8'd6; b0 = 8'd7; req0 = 1'b1;
    wait_gnt(w, c);
    req0 = 1'b0;
    wait_done(w, c);
    a1 = 8'd9; b1 = 8'd10; req1 = 1'b1;
    wait_gnt(w, c);
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done0 || done1) seen_done = 1'b1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (seen_done || result !== '0 || busy !== 1'b0 || owner !== 1'b0 || done0 || done1) begin
      errors++;
      $display("FAIL abort_state: early_done=%b result=%h busy=%b owner=%b, want 0/0000/0/0",
               seen_done, result, busy, owner);
    end
    @(negedge clk);
    reset = 1'b0;
    wait_gnt(w, c);
    req1 = 1'b0;
    checks++;
    if (w !== 1 || c !== 1) begin
      errors++;
      $display("FAIL abort_regrant: which=%0d cyc=%0d, want 1/1", w, c);
    end
    wait_done(w, c);
    checks++;
    if (w !== 1 || c !== W + 1 || result !== 16'd90) begin
      errors++;
      $display("FAIL abort_result: which=%0d cyc=%0d result=%0d, want 1/%0d/90", w, c, result, W + 1);
    end
  endtask

  task automatic test_idle_stable();
    int w, c;
    apply_reset();
    a0 = 8'd200; b0 = 8'd3; req0 = 1'b1;
    wait_gnt(w, c);
    req0 = 1'b0;
    wait_done(w, c);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, done0, done1, busy} !== 5'b0 || result !== 16'd600 || owner !== 1'b0) begin
        errors++;
        $display("FAIL idle_stable[%0d]: gnt=%b%b done=%b%b busy=%b result=%0d owner=%b, want quiet/600/0",
                 i, gnt0, gnt1, done0, done1, busy, result, owner);
      end
    end
  endtask

  // Model: a lone request wins; on contention the requester not granted last
  // time wins (requester 0 after reset). Product is plain a*b.
  task automatic test_random();
    int w, c, exp_w, exp_p;
    bit p0, p1;
    int last = 1;
    apply_reset();
    p0 = 1'b0;
    p1 = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (!p0 && $urandom_range(1, 0) == 1) begin
        a0 = ($urandom_range(3, 0) == 0) ? 8'hFF : W'($urandom);
        b0 = W'($urandom);
        req0 = 1'b1; p0 = 1'b1;
      end
      if (!p1 && $urandom_range(1, 0) == 1) begin
        a1 = W'($urandom);
        b1 = ($urandom_range(3, 0) == 0) ? 8'hFF : W'($urandom);
        req1 = 1'b1; p1 = 1'b1;
      end
      if (!p0 && !p1) begin
        a0 = W'($urandom); b0 = W'($urandom);
        req0 = 1'b1; p0 = 1'b1;
      end
      exp_w = (p0 && p1) ? 1 - last : (p1 ? 1 : 0);
      last  = exp_w;
      exp_p = (exp_w == 1) ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
      wait_gnt(w, c);
      if (w == 0) begin req0 = 1'b0; p0 = 1'b0; end
      if (w == 1) begin req1 = 1'b0; p1 = 1'b0; end
      checks++;
      if (w !== exp_w || c !== 1) begin
        errors++;
        $display("FAIL rand_gnt[%0d]: which=%0d cyc=%0d, want %0d/1", n, w, c, exp_w);
      end
      wait_done(w, c);
      checks++;
      if (w !== exp_w || c !== W + 1 || result !== 16'(exp_p) || owner !== exp_w[0]) begin
        errors++;
        $display("FAIL rand_done[%0d]: which=%0d cyc=%0d result=%0d owner=%b, want %0d/%0d/%0d/%0d",
                 n, w, c, result, owner, exp_w, W + 1, exp_p, exp_w);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_extremes();
    test_reset_abort();
    test_idle_stable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
